// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the run/step controller: run modes, halt causes and FSM states.
package cpu_run_ctrl_pkg;

  typedef logic [1:0] run_mode_t;
  typedef logic [1:0] halt_cause_t;

  localparam run_mode_t MODE_HALT  = 2'b00;
  localparam run_mode_t MODE_FREE  = 2'b01;
  localparam run_mode_t MODE_STEP  = 2'b10;
  localparam run_mode_t MODE_RUN_N = 2'b11;

  localparam halt_cause_t CAUSE_NONE  = 2'd0;
  localparam halt_cause_t CAUSE_STOP  = 2'd1;
  localparam halt_cause_t CAUSE_BP    = 2'd2;
  localparam halt_cause_t CAUSE_COUNT = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/cpu_bp_match.sv
// Parallel PC breakpoint comparators with a lowest-index priority encoder (combinational).
module cpu_bp_match
  import cpu_run_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NUM_BP = 2
) (
  input  logic [XLEN-1:0]        pc,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [NUM_BP*XLEN-1:0] bp_addr,
  output logic                   hit,
  output logic [2:0]             idx
);

  always_comb begin
    hit = 1'b0;
    idx = 3'd0;
    // Scan from the top down so the lowest matching index is the one left standing.
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (pc == bp_addr[i*XLEN +: XLEN])) begin
        hit = 1'b1;
        idx = i[2:0];
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller gating the datapath clock enable: free-run, single-step,
// run-for-N-cycles and PC breakpoints.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CNT_W  = 32,
  parameter int NUM_BP = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   start,
  input  logic                   stop,
  input  logic [CNT_W-1:0]       run_count,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [NUM_BP*XLEN-1:0] bp_addr,
  input  logic [XLEN-1:0]        pc,
  output logic                   cpu_ce,
  output logic                   running,
  output logic                   done,
  output logic [1:0]             halt_cause,
  output logic [2:0]             bp_idx,
  output logic [CNT_W-1:0]       cycle_cnt
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [0:0]       state;
  logic             first_cyc;
  logic             limited;
  logic [CNT_W-1:0] remaining;
  logic             bp_raw;
  logic [2:0]       bp_idx_c;
  logic             bp_hit;
  logic             start_ok;

  cpu_bp_match #(
    .XLEN   (XLEN),
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .pc      (pc),
    .bp_en   (bp_en),
    .bp_addr (bp_addr),
    .hit     (bp_raw),
    .idx     (bp_idx_c)
  );

  // Masking the first cycle lets a resume from a breakpoint execute that instruction.
  assign bp_hit   = bp_raw && !first_cyc;
  assign running  = (state == ST_RUN);
  assign cpu_ce   = running && !stop && !bp_hit && !(limited && (remaining == CNT_ZERO));
  assign start_ok = (state == ST_IDLE) && start && !stop && (mode != MODE_HALT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      first_cyc  <= 1'b0;
      limited    <= 1'b0;
      remaining  <= CNT_ZERO;
      done       <= 1'b0;
      halt_cause <= CAUSE_NONE;
      bp_idx     <= 3'd0;
      cycle_cnt  <= CNT_ZERO;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start_ok) begin
          cycle_cnt  <= CNT_ZERO;
          halt_cause <= CAUSE_NONE;
          first_cyc  <= 1'b1;
          if (mode == MODE_FREE) begin
            limited   <= 1'b0;
            remaining <= CNT_ZERO;
          end else if (mode == MODE_STEP) begin
            limited   <= 1'b1;
            remaining <= CNT_ONE;
          end else begin
            limited   <= 1'b1;
            remaining <= run_count;
          end
          // A zero budget finishes without ever entering RUN.
          if ((mode == MODE_RUN_N) && (run_count == CNT_ZERO)) begin
            done       <= 1'b1;
            halt_cause <= CAUSE_COUNT;
          end else begin
            state <= ST_RUN;
          end
        end
      end else begin
        first_cyc <= 1'b0;
        if (cpu_ce) begin
          cycle_cnt <= sat_inc(cycle_cnt);
          if (limited) begin
            remaining <= remaining - CNT_ONE;
          end
        end
        if (stop) begin
          state      <= ST_IDLE;
          done       <= 1'b1;
          halt_cause <= CAUSE_STOP;
        end else if (bp_hit) begin
          state      <= ST_IDLE;
          done       <= 1'b1;
          halt_cause <= CAUSE_BP;
          bp_idx     <= bp_idx_c;
        end else if (limited && (remaining <= CNT_ONE)) begin
          state      <= ST_IDLE;
          done       <= 1'b1;
          halt_cause <= CAUSE_COUNT;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: per-cycle vector table plus hand sequences
// for reset mid-run, start-while-running and counter saturation.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        start, stop;
  logic [31:0] run_count;
  logic [1:0]  bp_en;
  logic [63:0] bp_addr;
  logic [31:0] pc;
  logic        cpu_ce, running, done;
  logic [1:0]  halt_cause;
  logic [2:0]  bp_idx;
  logic [31:0] cycle_cnt;

  logic [1:0]  s_mode;
  logic        s_start, s_stop;
  logic [3:0]  s_count;
  logic        s_ce, s_running, s_done;
  logic [1:0]  s_cause;
  logic [2:0]  s_idx;
  logic [3:0]  s_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.XLEN(32), .CNT_W(32), .NUM_BP(2)) dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start), .stop(stop),
    .run_count(run_count), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .cpu_ce(cpu_ce), .running(running), .done(done), .halt_cause(halt_cause),
    .bp_idx(bp_idx), .cycle_cnt(cycle_cnt)
  );

  cpu_run_ctrl #(.XLEN(32), .CNT_W(4), .NUM_BP(2)) dut4 (
    .clk(clk), .rst(rst), .mode(s_mode), .start(s_start), .stop(s_stop),
    .run_count(s_count), .bp_en(2'b00), .bp_addr(bp_addr), .pc(pc),
    .cpu_ce(s_ce), .running(s_running), .done(s_done), .halt_cause(s_cause),
    .bp_idx(s_idx), .cycle_cnt(s_cnt)
  );

  typedef struct {
    logic        r;
    logic [1:0]  m;
    logic        st, sp;
    logic [31:0] cnt;
    logic [1:0]  en;
    logic [31:0] pc;
    logic        ce, run, dn;
    logic [1:0]  cause;
    logic [2:0]  idx;
    logic [31:0] ccnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, input logic [1:0] m, input logic st, input logic sp,
                             input logic [31:0] cnt, input logic [1:0] en, input logic [31:0] p,
                             input logic ce, input logic run, input logic dn,
                             input logic [1:0] cause, input logic [2:0] idx, input logic [31:0] ccnt);
    vec_t x;
    x.r = r; x.m = m; x.st = st; x.sp = sp; x.cnt = cnt; x.en = en; x.pc = p;
    x.ce = ce; x.run = run; x.dn = dn; x.cause = cause; x.idx = idx; x.ccnt = ccnt;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  int  nce;
  logic done_seen;

  initial begin
    rst = 1'b0; mode = 2'b00; start = 1'b0; stop = 1'b0; run_count = '0;
    bp_en = 2'b00; pc = '0;
    bp_addr = {32'h0000_0020, 32'h0000_0010};
    s_mode = 2'b00; s_start = 1'b0; s_stop = 1'b0; s_count = '0;

    // Columns: rst mode start stop run_count bp_en pc | ce running done cause idx cycle_cnt
    tbl.push_back(v(0,0,0,0,0,0,0,      0,0,0,0,0,0));
    // STEP
    tbl.push_back(v(1,2,1,0,0,0,0,      0,0,0,0,0,0));
    tbl.push_back(v(1,2,0,0,0,0,0,      1,1,0,0,0,0));
    tbl.push_back(v(1,2,0,0,0,0,0,      0,0,1,3,0,1));
    tbl.push_back(v(1,0,0,0,0,0,0,      0,0,0,3,0,1));
    // RUN_N = 5
    tbl.push_back(v(1,3,1,0,5,0,0,      0,0,0,3,0,1));
    for (int k = 0; k < 5; k++) tbl.push_back(v(1,3,0,0,5,0,0, 1,1,0,0,0,k));
    tbl.push_back(v(1,3,0,0,0,0,0,      0,0,1,3,0,5));
    tbl.push_back(v(1,0,0,0,0,0,0,      0,0,0,3,0,5));
    // RUN_N = 0
    tbl.push_back(v(1,3,1,0,0,0,0,      0,0,0,3,0,5));
    tbl.push_back(v(1,3,0,0,0,0,0,      0,0,1,3,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0,      0,0,0,3,0,0));
    // FREE into breakpoint 0 at 0x10
    tbl.push_back(v(1,1,1,0,0,1,0,      0,0,0,3,0,0));
    for (int k = 0; k < 4; k++) tbl.push_back(v(1,1,0,0,0,1,4*k, 1,1,0,0,0,k));
    tbl.push_back(v(1,1,0,0,0,1,'h10,   0,1,0,0,0,4));
    tbl.push_back(v(1,1,0,0,0,1,'h10,   0,0,1,2,0,4));
    // Resume from 0x10, then breakpoint 1 at 0x20
    tbl.push_back(v(1,1,1,0,0,1,'h10,   0,0,0,2,0,4));
    for (int k = 0; k < 3; k++) tbl.push_back(v(1,1,0,0,0,1,'h10+4*k, 1,1,0,0,0,k));
    tbl.push_back(v(1,1,0,0,0,3,'h1C,   1,1,0,0,0,3));
    tbl.push_back(v(1,1,0,0,0,3,'h20,   0,1,0,0,0,4));
    tbl.push_back(v(1,1,0,0,0,3,'h20,   0,0,1,2,1,4));
    // Resume at 0x20, then stop and bp match together: stop wins
    tbl.push_back(v(1,1,1,0,0,3,'h20,   0,0,0,2,1,4));
    tbl.push_back(v(1,1,0,0,0,3,'h20,   1,1,0,0,1,0));
    tbl.push_back(v(1,1,0,1,0,3,'h10,   0,1,0,0,1,1));
    tbl.push_back(v(1,1,0,0,0,3,'h10,   0,0,1,1,1,1));
    // start + stop together in IDLE: no run
    tbl.push_back(v(1,1,1,1,0,3,'h10,   0,0,0,1,1,1));
    tbl.push_back(v(1,1,0,0,0,3,'h10,   0,0,0,1,1,1));
    tbl.push_back(v(1,0,0,0,0,0,0,      0,0,0,1,1,1));

    repeat (2) @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].r; mode = tbl[i].m; start = tbl[i].st; stop = tbl[i].sp;
      run_count = tbl[i].cnt; bp_en = tbl[i].en; pc = tbl[i].pc;
      #1;
      chk($sformatf("row%0d cpu_ce", i),     {31'd0, cpu_ce},     {31'd0, tbl[i].ce});
      chk($sformatf("row%0d running", i),    {31'd0, running},    {31'd0, tbl[i].run});
      chk($sformatf("row%0d done", i),       {31'd0, done},       {31'd0, tbl[i].dn});
      chk($sformatf("row%0d halt_cause", i), {30'd0, halt_cause}, {30'd0, tbl[i].cause});
      chk($sformatf("row%0d bp_idx", i),     {29'd0, bp_idx},     {29'd0, tbl[i].idx});
      chk($sformatf("row%0d cycle_cnt", i),  cycle_cnt,           tbl[i].ccnt);
    end

    // RUN_N = 100, ignored start in RUN, reset at cycle 40
    @(negedge clk);
    mode = 2'b11; run_count = 32'd100; start = 1'b1; stop = 1'b0; bp_en = 2'b00; pc = '0;
    nce = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = (i == 20);
      #1;
      if (cpu_ce) nce++;
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("runn ce_cycles", nce, 40);
    chk("runn cycle_cnt_40", cycle_cnt, 40);
    chk("runn running_mid", {31'd0, running}, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst cpu_ce", {31'd0, cpu_ce}, 0);
    chk("rst running", {31'd0, running}, 0);
    chk("rst cycle_cnt", cycle_cnt, 0);
    done_seen = done;
    repeat (3) begin
      @(negedge clk);
      #1;
      done_seen = done_seen | done;
    end
    chk("rst no_done", {31'd0, done_seen}, 0);
    chk("rst cause", {30'd0, halt_cause}, 0);

    // CNT_W = 4 FREE for 20 cycles then stop
    @(negedge clk);
    s_mode = 2'b01; s_start = 1'b1;
    nce = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s_start = 1'b0;
      #1;
      if (s_ce) nce++;
    end
    @(negedge clk);
    s_stop = 1'b1;
    #1;
    chk("sat ce_cycles", nce, 20);
    chk("sat ce_on_stop", {31'd0, s_ce}, 0);
    chk("sat cycle_cnt_run", {28'd0, s_cnt}, 15);
    @(negedge clk);
    s_stop = 1'b0;
    #1;
    chk("sat done", {31'd0, s_done}, 1);
    chk("sat running", {31'd0, s_running}, 0);
    chk("sat cause", {30'd0, s_cause}, 1);
    chk("sat cycle_cnt", {28'd0, s_cnt}, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
